// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: shift-add multiplier, restoring divider.
// Optional MULDIV_EARLY_OUT_EN: trivial ops (div by 0, overflow, mul by 0) skip to DONE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               bz_q, bz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic             sgn_a, sgn_b;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
            (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) ||
            (funct3 == 3'b110);
    neg_a = sgn_a & op_a[WIDTH-1];
    neg_b = sgn_b & op_b[WIDTH-1];
    mag_a = neg_a ? -op_a : op_a;
    mag_b = neg_b ? -op_b : op_b;
  end

  // One iteration of either datapath; operand bits picked by count.
  logic [WIDTH-1:0]   acc_hi;
  logic [CW-1:0]      mul_idx;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_n;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    acc_hi  = acc_q[2*WIDTH-1:WIDTH];
    mul_idx = CMAX - cnt_q;
    addend  = mb_q[mul_idx] ? ma_q : '0;
    sum     = {1'b0, acc_hi} + {1'b0, addend};
    mul_nxt = {sum, acc_q[WIDTH-1:1]};
    sh      = {acc_hi, ma_q[cnt_q]};
    ge      = sh >= {1'b0, mb_q};
    diff    = sh[WIDTH-1:0] - mb_q;
    rem_n   = ge ? diff : sh[WIDTH-1:0];
    div_nxt = {rem_n, acc_q[WIDTH-2:0], ge};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   q_s, r_s;
  logic [WIDTH-1:0]   div_res;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    mul_res = (f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                   : prod[2*WIDTH-1:WIDTH];
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    q_s     = (sa_q ^ sb_q) ? -quo : quo;
    r_s     = sa_q ? -rem : rem;
    // Divide by zero: magnitude path already yields rem = |a|, only quo needs forcing.
    if (bz_q && !f3_q[1]) div_res = '1;
    else if (f3_q[1])     div_res = r_s;
    else                  div_res = q_s;
    fix_res = f3_q[2] ? div_res : mul_res;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic             b_zero, a_zero, ovf;
  logic             early;
  logic [WIDTH-1:0] early_res;

  always_comb begin
    b_zero = op_b == '0;
    a_zero = op_a == '0;
    ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
             (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    early  = funct3[2] ? (b_zero || ovf) : (a_zero || b_zero);
    early_res = '0;
    if (funct3[2] && b_zero) early_res = funct3[1] ? op_a : '1;
    else if (funct3[2])      early_res = funct3[1] ? '0 : op_a;
  end
`endif

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          f3_d    = funct3;
          ma_d    = mag_a;
          mb_d    = mag_b;
          sa_d    = neg_a;
          sb_d    = neg_b;
          bz_d    = op_b == '0;
          acc_d   = '0;
          cnt_d   = CMAX;
          state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            state_d = DONE;
            res_d   = early_res;
          end
`endif
        end
      end
      CALC: begin
        acc_d = f3_q[2] ? div_nxt : mul_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
    if (kill && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer (WIDTH=32).
// Honours MULDIV_EARLY_OUT_EN for expected latency.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [31:0] last_res;
  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int ia, ib;
    ia = a;
    ib = b;
    model = '0;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; model = p[31:0]; end
      3'd1: begin p = longint'(ia) * longint'(ib); model = p[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'b0, b}); model = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; model = p[63:32]; end
      3'd4: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = a;
        else model = ia / ib;
      end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 0;
        else model = ia % ib;
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b);
    lat_of = 34;
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2]) begin
      if (b == 0) lat_of = 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 &&
          b == 32'hFFFF_FFFF) lat_of = 1;
    end else if (a == 0 || b == 0) lat_of = 1;
`endif
  endfunction

  task automatic launch(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit push,
                        input logic [31:0] exp);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n;
    bit bok;
    n = 1;
    bok = 1'b1;
    while (!done && n < 60) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b1) bok = 1'b0;
    check({tag, ":done"}, 32'(done), 32'd1);
    check({tag, ":lat"}, n, lat);
    check({tag, ":busy"}, 32'(bok), 32'd1);
    if (exp_q.size() > 0) begin
      last_res = exp_q.pop_front();
      check({tag, ":res"}, result, last_res);
    end else begin
      check({tag, ":sb_empty"}, 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    check({tag, ":pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    launch(f, a, b, 1'b1, exp);
    wait_done(tag, lat_of(f, a, b));
  endtask

  initial begin
    int dn;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    n_chk = 0;
    n_pass = 0;
    last_res = '0;
    reset = 1'b0;
    start = 1'b0;
    kill = 1'b0;
    funct3 = '0;
    op_a = '0;
    op_b = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
    run("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    run("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("rem0", 3'd6, 32'd5, 32'd0, 32'd5);
    run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("mulz", 3'd1, 32'd0, 32'h1234_5678, 32'd0);

    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      run("rand", rf, ra, rb, model(rf, ra, rb));
    end

    // Flush in CALC cycle 10.
    dn = 0;
    launch(3'd0, 32'd3, 32'd5, 1'b0, 32'd0);
    repeat (9) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_nodone", dn + 32'(done), 32'd0);
    check("kill_res", result, last_res);
    run("after_kill", 3'd0, 32'd6, 32'd9, 32'd54);

    // Kill beats start while idle.
    kill = 1'b1;
    launch(3'd5, 32'd9, 32'd3, 1'b0, 32'd0);
    kill = 1'b0;
    check("kill_idle", 32'(busy), 32'd0);

    // Start held high across the whole operation.
    dn = 0;
    funct3 = 3'd5;
    op_a = 32'd1000;
    op_b = 32'd7;
    start = 1'b1;
    exp_q.push_back(32'd142);
    @(posedge clk); #1;
    for (int c = 1; c < 45; c++) begin
      if (done) begin
        dn++;
        start = 1'b0;
        check("hold_res", result, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("hold_count", dn, 32'd1);
    check("hold_idle", 32'(busy), 32'd0);

    // Asynchronous reset in CALC.
    launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_res", result, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run("post_rst", 3'd7, 32'd77, 32'd10, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
